mix_columns_engine: RTL and testbench

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

---
 rtl/mix_columns_engine.sv | 158 +++++++++++++++
 tb/tb_mix_columns_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: captures one 128-bit state, transforms
// COLS_PER_CYCLE columns per cycle into an output register, then holds it for the consumer.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         mode_dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // With four columns per cycle the step wraps to 0 and the single BUSY cycle ends at 0.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [1:0]    r_cnt;
  logic          r_mode;
  logic [127:0]  r_state_in;
  logic [127:0]  r_state_out;
  logic [127:0]  w_next_out;
  logic          w_accept;

  logic [1:0]    w_col_idx [COLS_PER_CYCLE];
  logic [31:0]   w_col_in  [COLS_PER_CYCLE];
  logic [31:0]   w_col_fwd [COLS_PER_CYCLE];
  logic [31:0]   w_col_out [COLS_PER_CYCLE];

  // GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] o0, o1, o2, o3;
    s0 = col[7:0];
    s1 = col[15:8];
    s2 = col[23:16];
    s3 = col[31:24];
    o0 = xtime(s0) ^ (xtime(s1) ^ s1) ^ s2 ^ s3;
    o1 = s0 ^ xtime(s1) ^ (xtime(s2) ^ s2) ^ s3;
    o2 = s0 ^ s1 ^ xtime(s2) ^ (xtime(s3) ^ s3);
    o3 = (xtime(s0) ^ s0) ^ s1 ^ s2 ^ xtime(s3);
    return {o3, o2, o1, o0};
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] o0, o1, o2, o3;
    s0 = col[7:0];
    s1 = col[15:8];
    s2 = col[23:16];
    s3 = col[31:24];
    o0 = mul14(s0) ^ mul11(s1) ^ mul13(s2) ^ mul9(s3);
    o1 = mul9(s0)  ^ mul14(s1) ^ mul11(s2) ^ mul13(s3);
    o2 = mul13(s0) ^ mul9(s1)  ^ mul14(s2) ^ mul11(s3);
    o3 = mul11(s0) ^ mul13(s1) ^ mul9(s2)  ^ mul14(s3);
    return {o3, o2, o1, o0};
  endfunction

  assign w_accept = (r_state == S_IDLE) && in_valid;

  for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
    assign w_col_idx[l] = r_cnt + 2'(l);
    assign w_col_in[l]  = r_state_in[{w_col_idx[l], 5'b0} +: 32];
    assign w_col_fwd[l] = mix_fwd(w_col_in[l]);
    if (INV_EN) begin : g_inv
      assign w_col_out[l] = r_mode ? mix_inv(w_col_in[l]) : w_col_fwd[l];
    end else begin : g_fwd_only
      assign w_col_out[l] = w_col_fwd[l];
    end
  end

  // NOTE: every always_comb output gets a full default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_out = r_state_out;
    for (int l = 0; l < COLS_PER_CYCLE; l++) begin
      w_next_out[{w_col_idx[l], 5'b0} +: 32] = w_col_out[l];
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)          w_next_state = S_BUSY;
      S_BUSY:  if (r_cnt == CNT_LAST) w_next_state = S_DONE;
      S_DONE:  if (out_ready)         w_next_state = S_IDLE;
      default:                        w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_mode      <= 1'b0;
      r_state_out <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cnt  <= 2'd0;
        r_mode <= INV_EN ? mode_dec : 1'b0;
      end else if (r_state == S_BUSY) begin
        r_cnt       <= r_cnt + CNT_STEP;
        r_state_out <= w_next_out;
      end
    end
  end

  // NOTE: the captured input is pure data qualified by the FSM, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_state_in <= state_in;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign state_out = r_state_out;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine: four instances (1/2/4 columns per cycle, and
// forward-only) share one stimulus stream; each instance is checked against hand-derived vectors.
module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] state_in;
  logic         mode_dec;
  logic         out_ready;

  logic         in_ready  [4];
  logic         out_valid [4];
  logic         busy      [4];
  logic [127:0] state_out [4];

  int n_vec = 0;
  int n_err = 0;
  int ncyc [4] = '{4, 2, 1, 4};

  // Columns listed top-down c3..c0; each column word is {row3,row2,row1,row0}.
  localparam logic [127:0] S_FWD = 128'hc6c6c6c6_01010101_5c220af2_455313db;
  localparam logic [127:0] E_FWD = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
  localparam logic [127:0] S_D   = 128'hd5d4d4d4_d5d4d4d4_d5d4d4d4_d5d4d4d4;
  localparam logic [127:0] E_D   = 128'hd6d7d5d5_d6d7d5d5_d6d7d5d5_d6d7d5d5;

  always #5 clk = ~clk;

  mix_columns_engine #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .state_in(state_in),
    .mode_dec(mode_dec), .out_valid(out_valid[0]), .out_ready(out_ready),
    .state_out(state_out[0]), .busy(busy[0]));

  mix_columns_engine #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .state_in(state_in),
    .mode_dec(mode_dec), .out_valid(out_valid[1]), .out_ready(out_ready),
    .state_out(state_out[1]), .busy(busy[1]));

  mix_columns_engine #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .state_in(state_in),
    .mode_dec(mode_dec), .out_valid(out_valid[2]), .out_ready(out_ready),
    .state_out(state_out[2]), .busy(busy[2]));

  mix_columns_engine #(.COLS_PER_CYCLE(1), .INV_EN(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]), .state_in(state_in),
    .mode_dec(mode_dec), .out_valid(out_valid[3]), .out_ready(out_ready),
    .state_out(state_out[3]), .busy(busy[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
        n_err++;
        $display("FAIL %s dut%0d: in_ready/out_valid/busy = %b%b%b, expected 100",
                 name, d, in_ready[d], out_valid[d], busy[d]);
      end
    end
  endtask

  // Accepts one state, checks the out_valid rise cycle of each instance, then the results.
  task automatic transact(input logic [127:0] st, input logic md, input logic [127:0] exp_inv,
                          input logic [127:0] exp_fo, input logic [3:0] mask,
                          input bit toggle_mode, input string name);
    logic [127:0] exp;
    state_in = st;
    mode_dec = md;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int d = 0; d < 4; d++) begin
        n_vec++;
        if (out_valid[d] !== (k >= ncyc[d]) || busy[d] !== 1'b1 || in_ready[d] !== 1'b0) begin
          n_err++;
          $display("FAIL %s_latency dut%0d k=%0d: out_valid/busy/in_ready = %b%b%b, expected %b10",
                   name, d, k, out_valid[d], busy[d], in_ready[d], (k >= ncyc[d]));
        end
      end
      if (toggle_mode) mode_dec = ~mode_dec;
      step();
    end
    for (int d = 0; d < 4; d++) begin
      if (mask[d]) begin
        exp = (d == 3) ? exp_fo : exp_inv;
        n_vec++;
        if (state_out[d] !== exp) begin
          n_err++;
          $display("FAIL %s_data dut%0d: got %h expected %h", name, d, state_out[d], exp);
        end
      end
    end
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_idle(name);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    state_in  = '0;
    mode_dec  = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check_idle("reset");
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (state_out[d] !== 128'h0) begin
        n_err++;
        $display("FAIL reset_state_out dut%0d: got %h expected 0", d, state_out[d]);
      end
    end
  endtask

  task automatic test_forward();
    transact(S_FWD, 1'b0, E_FWD, E_FWD, 4'b1111, 1'b0, "forward");
    release_out("forward_release");
  endtask

  task automatic test_inverse();
    transact(E_FWD, 1'b1, S_FWD, '0, 4'b0111, 1'b0, "inverse");
    release_out("inverse_release");
    transact(S_FWD, 1'b1, '0, E_FWD, 4'b1000, 1'b0, "inv_disabled");
    release_out("inv_disabled_release");
  endtask

  task automatic test_backpressure();
    transact(S_FWD, 1'b0, E_FWD, E_FWD, 4'b1111, 1'b0, "bp_setup");
    state_in = S_D;
    mode_dec = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        n_vec++;
        if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || state_out[d] !== E_FWD) begin
          n_err++;
          $display("FAIL backpressure dut%0d k=%0d: out_valid=%b in_ready=%b state_out=%h, expected 1 0 %h",
                   d, k, out_valid[d], in_ready[d], state_out[d], E_FWD);
        end
      end
    end
    in_valid = 1'b0;
    release_out("bp_release");
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (state_out[d] !== E_FWD) begin
        n_err++;
        $display("FAIL bp_hold dut%0d: got %h expected %h", d, state_out[d], E_FWD);
      end
    end
  endtask

  task automatic test_reset_abort();
    state_in = S_FWD;
    mode_dec = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("abort");
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (state_out[d] !== 128'h0) begin
        n_err++;
        $display("FAIL abort_state_out dut%0d: got %h expected 0", d, state_out[d]);
      end
    end
    step();
    check_idle("abort_settle");
    transact(S_D, 1'b0, E_D, E_D, 4'b1111, 1'b0, "after_abort");
    release_out("after_abort_release");
  endtask

  task automatic test_mode_change();
    transact(S_FWD, 1'b0, E_FWD, E_FWD, 4'b1111, 1'b1, "mode_change");
    release_out("mode_change_release");
  endtask

  task automatic test_back_to_back();
    int pulses [4] = '{0, 0, 0, 0};
    int exp_pulses [4] = '{3, 5, 6, 3};
    state_in  = S_FWD;
    mode_dec  = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    for (int k = 1; k <= 18; k++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        if (out_valid[d] === 1'b1) pulses[d]++;
      end
    end
    in_valid = 1'b0;
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (pulses[d] !== exp_pulses[d]) begin
        n_err++;
        $display("FAIL throughput dut%0d: %0d results in 18 cycles, expected %0d",
                 d, pulses[d], exp_pulses[d]);
      end
    end
    repeat (8) step();
    out_ready = 1'b0;
    check_idle("b2b_drain");
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (state_out[d] !== E_FWD) begin
        n_err++;
        $display("FAIL b2b_data dut%0d: got %h expected %h", d, state_out[d], E_FWD);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_backpressure();
    test_reset_abort();
    test_mode_change();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
